loss: RTL
=========

// Module: loss
// PURPOSE
//  Output-layer error source: other end of the sigmoid backward channel.
//  - Joins the activation stream (res) with a target stream (tgt).
//  - Forms err = sat((tgt - res) << GAIN) in signed Q8.8 and presents it on
//    a valid/ready channel that drives the sigmoid backward err input.
//  - Keeps sample and miss counters for training monitors.
// PARAMETERS
//  RESW  8   activation/target width, unsigned Q0.8 (0x80 = 0.5)
//  ERRW  16  error width, signed Q8.8 (0x0100 = 1.0)
//  GAIN  0   left shift applied to the difference (learning-rate scale), 0..8
//  TOL   4   miss threshold: sample is a miss when |tgt-res| > TOL (LSBs)
//  CNTW  16  width of the sample and miss counters
// PORTS
//  clock      in   1     single clock, all state on its rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  en         in   1     1 = training (err emitted), 0 = inference (stats only)
//  clear      in   1     synchronous clear of both counters
//  res        in   RESW  activation from sigmoid forward result
//  res_valid  in   1     res handshake
//  res_ready  out  1     res handshake
//  tgt        in   RESW  target value, same Q0.8 format
//  tgt_valid  in   1     tgt handshake
//  tgt_ready  out  1     tgt handshake
//  err        out  ERRW  signed error to sigmoid backward input
//  err_valid  out  1     err handshake
//  err_ready  in   1     err handshake
//  count      out  CNTW  samples accepted since reset/clear
//  miss       out  CNTW  samples with |tgt-res| > TOL
// BEHAVIOUR
//  - Reset (async, reset_n=0): err_valid=0, err=0, count=0, miss=0. Takes
//    effect immediately, including mid-transfer; a pending err is dropped.
//  - Output slot FSM: EMPTY (err_valid=0) / FULL (err_valid=1).
//  - take = res_valid & tgt_valid & (!en | EMPTY | err_ready).
//  - res_ready = tgt_ready = take (combinational). A pair is consumed
//    atomically; one side is never consumed alone.
//  - en=1, on take: err <= sat(d), FSM -> FULL. Latency 1 cycle.
//    Throughput 1 pair/cycle when err_ready=1.
//  - FULL & err_ready & !take -> EMPTY.
//  - FULL & err_ready & take -> stays FULL with the new err.
//  - While FULL & !err_ready: err and err_valid stay stable; take=0.
//  - en=0: pairs are consumed whenever both valid; no err is produced.
//    An err already FULL still drains normally.
//  - Arithmetic:
//    - d = sext(tgt) - sext(res), 9-bit signed.
//    - Scale as d * 2^GAIN at full precision (9+GAIN bits).
//    - Saturate to [-2^(ERRW-1), 2^(ERRW-1)-1].
//    - GAIN=0 never saturates.
//  - Counters:
//    - On take: count += 1, wrapping modulo 2^CNTW.
//    - miss += 1 when |d| > TOL; miss saturates at all-ones.
//    - Counting is independent of en.
//  - clear has priority: a take in the same cycle is not counted;
//    both counters read 0 next cycle.
// STRUCTURE
//  - machina_pkg holds:
//    - typedefs act_t (RESW) and err_t (signed ERRW)
//    - sat_shift(d, gain) function
//    - Q8.8 ONE constant 16'h0100
//  - Sub-module pipe_reg: 1-entry valid/ready register slice for the err
//    channel (EMPTY/FULL FSM), reusable on other backward paths.
//  - Join, arithmetic and counters stay in loss.
// TESTING
//  1. en=1, err_ready=1, res=8'h80, tgt=8'hff
//     -> next cycle err=16'h007f, err_valid=1, count=1, miss=1.
//  2. res=8'hff, tgt=8'h00 -> err=16'hff01.
//     res=8'h80, tgt=8'h80 -> err=16'h0000, miss unchanged.
//  3. GAIN=8: res=8'h00, tgt=8'hff -> err=16'h7fff.
//     GAIN=8: res=8'hff, tgt=8'h00 -> err=16'h8000.
//  4. Both inputs valid, err_ready=0 for 3 cycles after first take
//     -> err stable, res_ready=tgt_ready=0, count=1.
//     Then err_ready=1 -> second err follows with no bubble.
//  5. en=0, res=8'h80, tgt=8'h86 -> err_valid stays 0, count=1, miss=1.
//     Then clear with a take in the same cycle -> count=0, miss=0.
//  6. reset_n low for 1 cycle while err_valid=1
//     -> err_valid=0 asynchronously, counters 0.
//     Then loop through sigmoid uut: res=8'h80, tgt=8'hff -> fbk=16'h001f.

Source files
------------

// File: rtl/machina_pkg.sv
// Shared types and helpers for the training datapath: Q0.8 activations,
// signed Q8.8 errors and the saturating scale used on backward paths.
package machina_pkg;

    localparam int unsigned ACTW = 8;
    localparam int unsigned EW   = 16;

    typedef logic [ACTW-1:0]      act_t;
    typedef logic signed [EW-1:0] err_t;

    localparam err_t ONE = 16'h0100;

    typedef enum logic {StEmpty, StFull} slot_t;

    // Shift d left by gain at full precision, then clamp to a signed errw-bit range.
    function automatic logic signed [31:0] sat_shift(input logic signed [31:0] d,
                                                     input int unsigned gain,
                                                     input int unsigned errw);
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = d <<< gain;
        hi = (32'sd1 <<< (errw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi) begin
            sat_shift = hi;
        end else if (s < lo) begin
            sat_shift = lo;
        end else begin
            sat_shift = s;
        end
    endfunction

endpackage

// File: rtl/loss_pipe_reg.sv
// One-entry valid/ready register slice (EMPTY/FULL) for a backward channel.
// Accepts a new word in the same cycle the held word drains.
module pipe_reg
    import machina_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    slot_t        state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        in_ready = (state_q == StEmpty) | out_ready;
        load     = in_valid & in_ready;
        if (load) begin
            state_d = StFull;
            data_d  = in_data;
        end else if ((state_q == StFull) && out_ready) begin
            state_d = StEmpty;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == StFull);

endmodule

// File: rtl/loss.sv
// Output-layer error source: joins activation and target streams, emits the
// scaled saturated error toward the sigmoid backward input and keeps stats.
module loss
    import machina_pkg::*;
#(
    parameter int unsigned RESW = 8,
    parameter int unsigned ERRW = 16,
    parameter int unsigned GAIN = 0,
    parameter int unsigned TOL  = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            en,
    input  logic            clear,
    input  logic [RESW-1:0] res,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [RESW-1:0] tgt,
    input  logic            tgt_valid,
    output logic            tgt_ready,
    output logic [ERRW-1:0] err,
    output logic            err_valid,
    input  logic            err_ready,
    output logic [CNTW-1:0] count,
    output logic [CNTW-1:0] miss
);

    logic                   both_valid;
    logic                   slot_ready;
    logic                   take;
    logic signed [RESW:0]   d;
    logic [RESW:0]          d_abs;
    logic signed [31:0]     d_ext;
    logic [ERRW-1:0]        err_new;
    logic                   is_miss;
    logic [CNTW-1:0]        count_q, count_d;
    logic [CNTW-1:0]        miss_q, miss_d;

    assign both_valid = res_valid & tgt_valid;
    // In inference the pair is consumed regardless of the err slot state.
    assign take       = both_valid & (~en | slot_ready);
    assign res_ready  = take;
    assign tgt_ready  = take;

    assign d       = $signed({1'b0, tgt}) - $signed({1'b0, res});
    assign d_abs   = d[RESW] ? -d : d;
    assign d_ext   = {{(31 - RESW){d[RESW]}}, d};
    assign err_new = ERRW'(sat_shift(d_ext, GAIN, ERRW));
    assign is_miss = d_abs > (RESW + 1)'(TOL);

    pipe_reg #(
        .W (ERRW)
    ) u_err_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (err_new),
        .in_valid  (both_valid & en),
        .in_ready  (slot_ready),
        .out_data  (err),
        .out_valid (err_valid),
        .out_ready (err_ready)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            miss_q  <= '0;
        end else begin
            count_q <= count_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        count_d = count_q;
        miss_d  = miss_q;
        if (clear) begin
            count_d = '0;
            miss_d  = '0;
        end else if (take) begin
            count_d = count_q + 1'b1;
            if (is_miss && (miss_q != '1)) begin
                miss_d = miss_q + 1'b1;
            end
        end
    end

    assign count = count_q;
    assign miss  = miss_q;

endmodule
